// File: rtl/req_enc_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 8-to-3 request encoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package req_enc_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One-hot mask with only bit idx set; used to retire a granted request.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_find_8.sv
// Priority search over 8 candidate bits; fixed (bit 7 highest) or rotating from base+1
// when REQ_ENCODER_ROUND_ROBIN_EN is defined. Latency: combinational.
// Backpressure: none; purely a function of vec/base.
module prio_find_8
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] w_pos;

  // Ascending search starting just after base, wrapping; first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    w_pos = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos = base + IDX_W'(k);
      if (!found && vec[w_pos]) begin
        idx   = w_pos;
        found = 1'b1;
      end
    end
  end
`else
  // base carries no information in fixed-priority mode.
  logic w_unused_base;
  assign w_unused_base = ^base;

  // Ascending scan where later hits overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (vec[k]) begin
        idx   = IDX_W'(k);
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/req_encoder_8to3.sv
// Sticky 8-line request capture, priority-encoded to a 3-bit code on valid/ready
// (round-robin selection when REQ_ENCODER_ROUND_ROBIN_EN is defined). Latency: 1 clock req->valid.
// Backpressure: code held stable while ready=0; back-to-back grants at 1 per clock on handshake.
module req_encoder_8to3
  import req_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] code,
  output logic             valid,
  input  logic             ready,
  output logic [N_REQ-1:0] pending
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_code;
  logic [IDX_W-1:0] w_code_nxt;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] w_req_m;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_cand;
  logic             w_hs;
  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  assign w_hs    = (r_state == HOLD) & ready;
  // en is active-low: high blocks new requests but leaves pending bits alone.
  assign w_req_m = en ? '0 : req;
  assign w_clr   = w_hs ? onehot(r_code) : '0;
  // Set after clear, so a request still held while granted re-pends.
  assign w_cand  = (r_pending & ~w_clr) | w_req_m;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_last;

  // Last-grant pointer; starts at 7 so the first search begins at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_last <= IDX_W'(7);
    else if (w_hs) r_last <= r_code;
  end

  // The grant completing this cycle is the effective "last" for the next pick.
  assign w_base = w_hs ? r_code : r_last;
`else
  assign w_base = IDX_W'(7);
`endif

  prio_find_8 u_prio_find (
    .vec   (w_cand),
    .base  (w_base),
    .idx   (w_idx),
    .found (w_found)
  );

  // Next-state and next-code: load on entry to HOLD or on handshake, otherwise hold.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = HOLD;
          w_code_nxt  = w_idx;
        end
      end
      HOLD: begin
        if (w_hs) begin
          if (w_found) w_code_nxt  = w_idx;
          else         w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, code and pending registers; pending tracks the candidate set every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_pending <= w_cand;
    end
  end

  assign valid   = (r_state == HOLD);
  assign code    = r_code;
  assign pending = r_pending;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Self-checking bench for req_encoder_8to3: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
// Honours REQ_ENCODER_ROUND_ROBIN_EN to select the expected grant order.
module tb_req_encoder_8to3;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic [7:0] req   = 8'h00;
  logic       ready = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  req_encoder_8to3 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_pend  = 0;
  bit m_valid = 1'b0;
  int m_code  = 0;
  int m_last  = 7;

  function automatic int pick(input int c, input int last);
    if (RR) begin
      for (int k = 1; k <= 8; k++) begin
        int p;
        p = (last + k) % 8;
        if (((c >> p) & 1) == 1) return p;
      end
    end else begin
      for (int p = 7; p >= 0; p--)
        if (((c >> p) & 1) == 1) return p;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int c;
    bit hs;
    if (!rst_n) begin
      m_pend  = 0;
      m_valid = 1'b0;
      m_code  = 0;
      m_last  = 7;
    end else begin
      hs = m_valid && ready;
      c  = m_pend;
      if (hs) c = c & ~(1 << m_code);
      if (!en) c = c | int'(req);
      if (!m_valid || hs) begin
        if (hs) m_last = m_code;
        if (c != 0) begin
          m_valid = 1'b1;
          m_code  = pick(c, m_last);
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = c;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("valid", int'(valid), int'(m_valid));
    chk("code", int'(code), m_code);
    chk("pending", int'(pending), m_pend);
  end

  task automatic step(input logic [7:0] r, input logic e, input logic rd);
    req   = r;
    en    = e;
    ready = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int burst[4];
    int exp_b;
    burst = '{7, 5, 2, 0};

    // Reset with all requests asserted.
    #1 rst_n = 1'b0;
    req = 8'hFF; en = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_pending", int'(pending), 0);
    #2 rst_n = 1'b1;

    // First grant one cycle after release, then drain all eight.
    step(8'hFF, 1'b0, 1'b0);
    chk("first_valid", int'(valid), 1);
    chk("first_code", int'(code), RR ? 0 : 7);
    chk("first_pending", int'(pending), 8'hFF);
    for (int i = 1; i < 8; i++) begin
      step(8'h00, 1'b0, 1'b1);
      chk("drain_code", int'(code), RR ? i : 7 - i);
    end
    step(8'h00, 1'b0, 1'b1);
    chk("drain_idle", int'(valid), 0);

    // Single one-cycle request.
    step(8'h04, 1'b0, 1'b1);
    chk("single_code", int'(code), 2);
    chk("single_valid", int'(valid), 1);
    step(8'h00, 1'b0, 1'b1);
    chk("single_idle", int'(valid), 0);
    chk("single_pend", int'(pending), 0);

    // Backpressure: no preemption by a later higher-priority request.
    step(8'h01, 1'b0, 1'b0);
    chk("bp_code0", int'(code), 0);
    for (int i = 0; i < 4; i++) begin
      step(8'h81, 1'b0, 1'b0);
      chk("bp_hold", int'(code), 0);
      chk("bp_valid", int'(valid), 1);
    end
    step(8'h00, 1'b0, 1'b1);
    chk("bp_next_valid", int'(valid), 1);
    chk("bp_next_code", int'(code), 7);
    step(8'h00, 1'b0, 1'b1);
    chk("bp_idle", int'(valid), 0);

    // Burst drain of a one-cycle pulse.
    step(8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_b = RR ? burst[3 - i] : burst[i];
      chk("burst_code", int'(code), exp_b);
      chk("burst_valid", int'(valid), 1);
      step(8'h00, 1'b0, 1'b1);
    end
    chk("burst_idle", int'(valid), 0);

    // Enable gating: new requests blocked, pending ones still served.
    step(8'h10, 1'b1, 1'b1);
    chk("gate_valid", int'(valid), 0);
    chk("gate_pend", int'(pending), 0);
    step(8'h08, 1'b0, 1'b0);
    chk("gate_code3", int'(code), 3);
    step(8'h02, 1'b0, 1'b0);
    chk("gate_pend2", int'(pending), 8'h0A);
    step(8'h00, 1'b1, 1'b1);
    chk("gate_code1", int'(code), 1);
    chk("gate_valid1", int'(valid), 1);
    step(8'h10, 1'b1, 1'b1);
    chk("gate_done", int'(valid), 0);

    // Reset mid-HOLD drops valid immediately.
    step(8'hFF, 1'b0, 1'b0);
    chk("pre_rst_valid", int'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", int'(valid), 0);
    chk("async_pend", int'(pending), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // All requests held with ready=1.
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0, 1'b1);
      chk("held_code", int'(code), RR ? (i % 8) : 7);
    end
    step(8'h00, 1'b1, 1'b1);

    // Randomized traffic, checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      logic       e;
      logic       rd;
      r  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      e  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 3) != 0);
      step(r, e, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
